// File: rtl/sc_reg_bank_pkg.sv
// Shared definitions for the sc_reg_bank register file: write-op encodings,
// register count and address width.
package sc_reg_bank_pkg;

  localparam int REG_COUNT  = 8;
  localparam int ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

endpackage

// File: rtl/sc_reg_bank_cell.sv
// One writable register of sc_reg_bank: decodes the write op when selected and
// exposes the value it will hold after the next rising edge.
module sc_reg_bank_cell
  import sc_reg_bank_pkg::*;
#(
  parameter int                WIDTH = 32,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  op_e               op,
  input  logic              sel,
  input  logic [WIDTH-1:0]  data,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  next_q
);

  // NOTE: next_q gets its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    next_q = q;
    if (sel) begin
      case (op)
        OP_LOAD: next_q = data;
        OP_INC:  next_q = q + WIDTH'(1);
        OP_CLR:  next_q = '0;
        default: next_q = q;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) q <= INIT;
    else     q <= next_q;
  end

endmodule

// File: rtl/sc_reg_bank.sv
// Eight-entry register bank, register 0 constant, two combinational read ports.
// Define SC_REGBANK_BYPASS_EN to forward the pending write value to the read ports.
module sc_reg_bank
  import sc_reg_bank_pkg::*;
#(
  parameter int                        DATAWIDTH_BUS    = 32,
  parameter logic [DATAWIDTH_BUS-1:0]  DATA_REG0_INIT   = '0,
  parameter logic [DATAWIDTH_BUS-1:0]  DATA_REGGEN_INIT = '0
) (
  input  logic                      SC_RegBANK_CLOCK_50,
  input  logic                      SC_RegBANK_RESET_InHigh,
  input  logic [1:0]                SC_RegBANK_WriteOp_InBus,
  input  logic [ADDR_WIDTH-1:0]     SC_RegBANK_WriteAddr_InBus,
  input  logic [DATAWIDTH_BUS-1:0]  SC_RegBANK_data_InBus,
  input  logic [ADDR_WIDTH-1:0]     SC_RegBANK_ReadAddrA_InBus,
  input  logic [ADDR_WIDTH-1:0]     SC_RegBANK_ReadAddrB_InBus,
  output logic [DATAWIDTH_BUS-1:0]  SC_RegBANK_dataA_OutBus,
  output logic [DATAWIDTH_BUS-1:0]  SC_RegBANK_dataB_OutBus,
  output logic                      SC_RegBANK_Carry_Out,
  output logic                      SC_RegBANK_WriteAck_Out
);

  op_e                      op;
  logic                     wr_valid;
  logic                     inc_wrap;
  logic [DATAWIDTH_BUS-1:0] regs      [REG_COUNT];
  logic [DATAWIDTH_BUS-1:0] next_vals [REG_COUNT];

  assign op       = op_e'(SC_RegBANK_WriteOp_InBus);
  assign wr_valid = (op != OP_NOP) && (SC_RegBANK_WriteAddr_InBus != '0);

  // Register 0 is a constant, so its "next value" is the constant too.
  assign regs[0]      = DATA_REG0_INIT;
  assign next_vals[0] = DATA_REG0_INIT;

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_cell
    sc_reg_bank_cell #(
      .WIDTH (DATAWIDTH_BUS),
      .INIT  (DATA_REGGEN_INIT)
    ) u_cell (
      .clk    (SC_RegBANK_CLOCK_50),
      .rst    (SC_RegBANK_RESET_InHigh),
      .op     (op),
      .sel    (SC_RegBANK_WriteAddr_InBus == ADDR_WIDTH'(i)),
      .data   (SC_RegBANK_data_InBus),
      .q      (regs[i]),
      .next_q (next_vals[i])
    );
  end

  // An increment wraps exactly when its result is zero.
  assign inc_wrap = (op == OP_INC) && (next_vals[SC_RegBANK_WriteAddr_InBus] == '0);

  always_comb begin
    SC_RegBANK_dataA_OutBus = regs[SC_RegBANK_ReadAddrA_InBus];
    SC_RegBANK_dataB_OutBus = regs[SC_RegBANK_ReadAddrB_InBus];
`ifdef SC_REGBANK_BYPASS_EN
    if (wr_valid && !SC_RegBANK_RESET_InHigh) begin
      if (SC_RegBANK_ReadAddrA_InBus == SC_RegBANK_WriteAddr_InBus)
        SC_RegBANK_dataA_OutBus = next_vals[SC_RegBANK_WriteAddr_InBus];
      if (SC_RegBANK_ReadAddrB_InBus == SC_RegBANK_WriteAddr_InBus)
        SC_RegBANK_dataB_OutBus = next_vals[SC_RegBANK_WriteAddr_InBus];
    end
`endif
  end

  // NOTE: reset is synchronous: it is only looked at inside the clocked block.
  always_ff @(posedge SC_RegBANK_CLOCK_50) begin
    if (SC_RegBANK_RESET_InHigh) begin
      SC_RegBANK_Carry_Out    <= 1'b0;
      SC_RegBANK_WriteAck_Out <= 1'b0;
    end else begin
      SC_RegBANK_WriteAck_Out <= wr_valid;
      if (wr_valid && op == OP_INC) SC_RegBANK_Carry_Out <= inc_wrap;
    end
  end

endmodule
